// File: rtl/lsu_array.sv
// lsu_array: one load/store FSM per thread driving the memory controller consumer ports.
// Each thread issues a single LDR/STR per REQUEST stage and parks in DONE until UPDATE.
module lsu_array #(
  parameter int NUM_THREADS    = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [2:0]                            core_state,
  input  logic                                  decoded_mem_read_en,
  input  logic                                  decoded_mem_write_en,
  input  logic [NUM_THREADS-1:0]                thread_enable,
  input  logic [NUM_THREADS-1:0][DATA_BITS-1:0] rs,
  input  logic [NUM_THREADS-1:0][DATA_BITS-1:0] rt,
  output logic [NUM_THREADS-1:0]                mem_read_valid,
  output logic [NUM_THREADS-1:0][ADDR_BITS-1:0] mem_read_address,
  input  logic [NUM_THREADS-1:0]                mem_read_ready,
  input  logic [NUM_THREADS-1:0][DATA_BITS-1:0] mem_read_data,
  output logic [NUM_THREADS-1:0]                mem_write_valid,
  output logic [NUM_THREADS-1:0][ADDR_BITS-1:0] mem_write_address,
  output logic [NUM_THREADS-1:0][DATA_BITS-1:0] mem_write_data,
  input  logic [NUM_THREADS-1:0]                mem_write_ready,
  output logic [NUM_THREADS-1:0][1:0]           lsu_state,
  output logic [NUM_THREADS-1:0][DATA_BITS-1:0] lsu_out,
  output logic [NUM_THREADS-1:0]                lsu_error,
  output logic                                  lsu_done
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam bit         TIMEOUT_ON   = (TIMEOUT_CYCLES > 32'sd0);
  localparam int         CNT_BITS     = (TIMEOUT_CYCLES > 32'sd1) ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = TIMEOUT_ON ? CNT_BITS'(TIMEOUT_CYCLES - 32'sd1) : {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_REQUESTING = 2'b01,
    ST_WAITING    = 2'b10,
    ST_DONE       = 2'b11
  } lsu_state_e;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_lsu
    lsu_state_e           state_r, state_s;
    logic                 is_read_r, is_read_s;
    logic [CNT_BITS-1:0]  count_r, count_s;
    logic                 read_valid_r, read_valid_s;
    logic                 write_valid_r, write_valid_s;
    logic [ADDR_BITS-1:0] addr_r, addr_s;
    logic [DATA_BITS-1:0] wdata_r, wdata_s;
    logic [DATA_BITS-1:0] out_r, out_s;
    logic                 error_r, error_s;
    logic                 ready_s, timeout_s;
    logic                 unused_rs_s;

    // Only the low address bits of rs are consumed.
    assign unused_rs_s = ^rs[i];

    // Next-state and datapath for this thread; enable=0 holds every register.
    always_comb begin
      state_s       = state_r;
      is_read_s     = is_read_r;
      count_s       = count_r;
      read_valid_s  = read_valid_r;
      write_valid_s = write_valid_r;
      addr_s        = addr_r;
      wdata_s       = wdata_r;
      out_s         = out_r;
      error_s       = error_r;
      ready_s       = is_read_r ? mem_read_ready[i] : mem_write_ready[i];
      timeout_s     = TIMEOUT_ON && (count_r == CNT_LAST);
      if (enable) begin
        case (state_r)
          ST_IDLE: begin
            if ((core_state == CORE_REQUEST) && thread_enable[i]) begin
              if (decoded_mem_read_en && decoded_mem_write_en) begin
                error_s = 1'b1;
              end else if ((decoded_mem_read_en ^ decoded_mem_write_en) &&
                           !mem_read_ready[i] && !mem_write_ready[i]) begin
                is_read_s = decoded_mem_read_en;
                state_s   = ST_REQUESTING;
              end else begin
                state_s = ST_IDLE;
              end
            end else begin
              state_s = ST_IDLE;
            end
          end
          ST_REQUESTING: begin
            addr_s  = rs[i][ADDR_BITS-1:0];
            count_s = {CNT_BITS{1'b0}};
            state_s = ST_WAITING;
            if (is_read_r) begin
              read_valid_s = 1'b1;
            end else begin
              write_valid_s = 1'b1;
              wdata_s       = rt[i];
            end
          end
          ST_WAITING: begin
            // A ready arriving in the last allowed cycle still completes normally.
            if (ready_s) begin
              read_valid_s  = 1'b0;
              write_valid_s = 1'b0;
              state_s       = ST_DONE;
              if (is_read_r) begin
                out_s = mem_read_data[i];
              end else begin
                out_s = out_r;
              end
            end else if (timeout_s) begin
              read_valid_s  = 1'b0;
              write_valid_s = 1'b0;
              error_s       = 1'b1;
              state_s       = ST_DONE;
            end else if (count_r != CNT_MAX) begin
              count_s = count_r + CNT_ONE;
            end else begin
              count_s = count_r;
            end
          end
          ST_DONE: begin
            if (core_state == CORE_UPDATE) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_DONE;
            end
          end
          default: state_s = ST_IDLE;
        endcase
      end else begin
        state_s = state_r;
      end
    end

    // Per-thread state register with synchronous reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r       <= ST_IDLE;
        is_read_r     <= 1'b0;
        count_r       <= {CNT_BITS{1'b0}};
        read_valid_r  <= 1'b0;
        write_valid_r <= 1'b0;
        addr_r        <= {ADDR_BITS{1'b0}};
        wdata_r       <= {DATA_BITS{1'b0}};
        out_r         <= {DATA_BITS{1'b0}};
        error_r       <= 1'b0;
      end else begin
        state_r       <= state_s;
        is_read_r     <= is_read_s;
        count_r       <= count_s;
        read_valid_r  <= read_valid_s;
        write_valid_r <= write_valid_s;
        addr_r        <= addr_s;
        wdata_r       <= wdata_s;
        out_r         <= out_s;
        error_r       <= error_s;
      end
    end

    assign mem_read_valid[i]    = read_valid_r;
    assign mem_read_address[i]  = addr_r;
    assign mem_write_valid[i]   = write_valid_r;
    assign mem_write_address[i] = addr_r;
    assign mem_write_data[i]    = wdata_r;
    assign lsu_state[i]         = state_r;
    assign lsu_out[i]           = out_r;
    assign lsu_error[i]         = error_r;
  end

  // Aggregate completion: disabled threads never hold the core back.
  always_comb begin
    lsu_done = 1'b1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (thread_enable[i] && (lsu_state[i] != ST_DONE)) begin
        lsu_done = 1'b0;
      end else begin
        lsu_done = lsu_done;
      end
    end
  end

endmodule

// File: tb/tb_lsu_array.sv
// Randomized bench for lsu_array: a transaction-level model predicts, per request, how many
// cycles the valid stays up, the returned data, the sticky error and the done aggregate.
module tb_lsu_array;
  localparam int NT = 4;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int TO = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [2:0]             core_state;
  logic                   rd_en, wr_en;
  logic [NT-1:0]          thread_enable;
  logic [NT-1:0][DB-1:0]  rs, rt;
  logic [NT-1:0]          mem_read_valid, mem_read_ready;
  logic [NT-1:0][AB-1:0]  mem_read_address, mem_write_address;
  logic [NT-1:0][DB-1:0]  mem_read_data, mem_write_data;
  logic [NT-1:0]          mem_write_valid, mem_write_ready;
  logic [NT-1:0][1:0]     lsu_state;
  logic [NT-1:0][DB-1:0]  lsu_out;
  logic [NT-1:0]          lsu_error;
  logic                   lsu_done;

  int pass_count = 0;
  int check_count = 0;

  logic [NT-1:0][DB-1:0] out_exp;
  logic [NT-1:0]         err_exp;

  lsu_array #(.NUM_THREADS(NT), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_en(rd_en), .decoded_mem_write_en(wr_en),
    .thread_enable(thread_enable), .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error), .lsu_done(lsu_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      pass_count++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_exp = '0;
    err_exp = '0;
  endtask

  // One REQUEST..UPDATE transaction. op: 0=LDR 1=STR 2=illegal both.
  // dly[i]: enabled WAITING cycle in which the responder raises the matching ready.
  task automatic run_op(input logic [NT-1:0] te, input logic [NT-1:0] te_after, input int op,
                        input logic [NT-1:0][DB-1:0] rs_v, input logic [NT-1:0][DB-1:0] rt_v,
                        input logic [NT-1:0][DB-1:0] rd_v, input logic [NT-1:0][3:0] dly,
                        input bit freeze5, input bit rnd_en);
    logic [NT-1:0] part, fin;
    int  cnt [NT];
    bit  is_rd, is_wr, hi, en, corr, noise;
    int  exp_cnt;
    is_rd = (op == 0) || (op == 2);
    is_wr = (op == 1) || (op == 2);
    part  = (op == 2) ? {NT{1'b0}} : te;
    fin   = '0;
    for (int i = 0; i < NT; i++) cnt[i] = 0;

    @(negedge clk);
    enable = 1'b1; core_state = 3'b011; rd_en = is_rd; wr_en = is_wr;
    thread_enable = te; rs = rs_v; rt = rt_v; mem_read_data = rd_v;
    mem_read_ready = '0; mem_write_ready = '0;
    @(negedge clk);
    for (int i = 0; i < NT; i++) check_eq("req_state", lsu_state[i], part[i] ? 2'b01 : 2'b00);
    core_state = 3'b100;
    thread_enable = te_after;
    if (op == 2) err_exp = err_exp | te;

    for (int k = 0; k < 40 && (fin != part); k++) begin
      @(negedge clk);
      for (int i = 0; i < NT; i++) begin
        if (part[i] && !fin[i]) begin
          hi = is_rd ? mem_read_valid[i] : mem_write_valid[i];
          if (hi) begin
            check_eq("wait_state", lsu_state[i], 2'b10);
            if (cnt[i] == 0 && is_rd) check_eq("rd_addr", mem_read_address[i], rs_v[i][AB-1:0]);
            if (cnt[i] == 0 && is_wr) check_eq("wr_addr", mem_write_address[i], rs_v[i][AB-1:0]);
            if (cnt[i] == 0 && is_wr) check_eq("wr_data", mem_write_data[i], rt_v[i]);
          end else begin
            fin[i] = 1'b1;
          end
        end else if (!part[i]) begin
          check_eq("idle_valid", {mem_read_valid[i], mem_write_valid[i]}, 2'b00);
        end
      end
      check_eq("done_mid", lsu_done, &(~te_after | fin));
      if (freeze5) en = !(k >= 1 && k <= 5);
      else if (rnd_en) en = ($urandom_range(0, 4) != 0);
      else en = 1'b1;
      enable = en;
      mem_read_ready = '0;
      mem_write_ready = '0;
      for (int i = 0; i < NT; i++) begin
        if (part[i] && !fin[i]) begin
          if (en) begin
            cnt[i]++;
            corr = (cnt[i] == int'(dly[i]));
          end else begin
            corr = 1'($urandom_range(0, 1));
          end
          noise = 1'($urandom_range(0, 1));
          if (is_rd) begin mem_read_ready[i] = corr; mem_write_ready[i] = noise; end
          else begin mem_write_ready[i] = corr; mem_read_ready[i] = noise; end
        end
      end
    end

    check_eq("all_finished", fin, part);
    for (int i = 0; i < NT; i++) begin
      if (part[i]) begin
        exp_cnt = (int'(dly[i]) > TO) ? TO : int'(dly[i]);
        check_eq("valid_cycles", cnt[i], exp_cnt);
        if (int'(dly[i]) > TO) err_exp[i] = 1'b1;
        else if (is_rd) out_exp[i] = rd_v[i];
      end
      check_eq("end_state", lsu_state[i], part[i] ? 2'b11 : 2'b00);
      check_eq("lsu_out", lsu_out[i], out_exp[i]);
    end
    check_eq("valid_end", {mem_read_valid, mem_write_valid}, '0);
    check_eq("lsu_error", lsu_error, err_exp);
    check_eq("done_end", lsu_done, &(~te_after | part));

    enable = 1'b1; core_state = 3'b110;
    mem_read_ready = '0; mem_write_ready = '0;
    @(negedge clk);
    core_state = 3'b000;
    check_eq("update_idle", lsu_state, '0);
    check_eq("update_done", lsu_done, te_after == '0);
    check_eq("err_sticky", lsu_error, err_exp);
  endtask

  logic [NT-1:0][DB-1:0] rs_v, rt_v, rd_v;
  logic [NT-1:0][3:0]    dly;
  logic [NT-1:0]         te, te2;
  int                    op;

  initial begin
    reset = 1'b1; enable = 1'b0; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
    thread_enable = '0; rs = '0; rt = '0; mem_read_ready = '0; mem_write_ready = '0;
    mem_read_data = '0; out_exp = '0; err_exp = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_state", lsu_state, '0);
    check_eq("rst_valid", {mem_read_valid, mem_write_valid}, '0);
    check_eq("rst_out", lsu_out, '0);
    check_eq("rst_err", lsu_error, '0);
    check_eq("rst_done_te0", lsu_done, 1'b1);
    thread_enable = 4'hF;
    #1;
    check_eq("rst_done_te1", lsu_done, 1'b0);

    // LDR on thread 0, ready in the 3rd waiting cycle.
    rs_v = '0; rt_v = '0; rd_v = '0; dly = '0;
    rs_v[0] = 16'h0012; rd_v[0] = 16'hBEEF; dly[0] = 4'd3;
    run_op(4'b0001, 4'b0001, 0, rs_v, rt_v, rd_v, dly, 1'b0, 1'b0);

    // STR on all threads, staggered acks; the last one lands in the final allowed cycle.
    for (int i = 0; i < NT; i++) begin
      rs_v[i] = 16'(i); rt_v[i] = 16'(16'h0100 + i); dly[i] = 4'(i + 1);
    end
    run_op(4'hF, 4'hF, 1, rs_v, rt_v, rd_v, dly, 1'b0, 1'b0);

    // No ready at all: timeout after TO cycles.
    dly = '0; dly[0] = 4'd9; rs_v[0] = 16'h00A5;
    run_op(4'b0001, 4'b0001, 0, rs_v, rt_v, rd_v, dly, 1'b0, 1'b0);

    // Illegal read+write decode.
    do_reset();
    run_op(4'hF, 4'hF, 2, rs_v, rt_v, rd_v, dly, 1'b0, 1'b0);

    // Load again so lsu_out is nonzero, then reset while waiting.
    do_reset();
    dly[0] = 4'd1; rd_v[0] = 16'h5A5A;
    run_op(4'b0001, 4'b0001, 0, rs_v, rt_v, rd_v, dly, 1'b0, 1'b0);
    @(negedge clk);
    core_state = 3'b011; rd_en = 1'b1; wr_en = 1'b0; thread_enable = 4'b0001;
    @(negedge clk);
    core_state = 3'b100;
    @(negedge clk);
    check_eq("pre_rst_valid", mem_read_valid[0], 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_exp = '0; err_exp = '0;
    check_eq("wrst_valid", mem_read_valid[0], 1'b0);
    check_eq("wrst_state", lsu_state[0], 2'b00);
    check_eq("wrst_out", lsu_out[0], 16'h0000);

    // Freeze for 5 cycles mid-wait.
    dly[0] = 4'd3; rd_v[0] = 16'h1234;
    run_op(4'b0001, 4'b0001, 0, rs_v, rt_v, rd_v, dly, 1'b1, 1'b0);

    // thread_enable drops mid-request without aborting.
    for (int i = 0; i < NT; i++) dly[i] = 4'd2;
    run_op(4'hF, 4'b0101, 1, rs_v, rt_v, rd_v, dly, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 7) do_reset();
      for (int i = 0; i < NT; i++) begin
        rs_v[i] = 16'($urandom); rt_v[i] = 16'($urandom); rd_v[i] = 16'($urandom);
        dly[i]  = 4'($urandom_range(1, 6));
      end
      te  = 4'($urandom_range(0, 15));
      te2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : te;
      op  = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
      run_op(te, te2, op, rs_v, rt_v, rd_v, dly, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
